// File: rtl/bridge_pkg.sv
// Shared types and width helpers for the SRAM port bridge.
package bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    function automatic int unsigned calc_bw(input int unsigned dw);
        return dw / 8;
    endfunction

    // Index width that stays legal for a single channel.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sram_port_bridge_if.sv
// Shared split-handshake memory port: request phase (addr_ok) then response phase (data_ok).
interface sram_port_bridge_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    localparam int unsigned BW = bridge_pkg::calc_bw(DW);

    logic          mem_req;
    logic          mem_wr;
    logic [BW-1:0] mem_wstrb;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_addr_ok;
    logic [DW-1:0] mem_rdata;
    logic          mem_data_ok;

    modport master (
        output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
        input  mem_addr_ok, mem_rdata, mem_data_ok
    );

    modport slave (
        input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
        output mem_addr_ok, mem_rdata, mem_data_ok
    );
endinterface

// File: rtl/sram_rr_arbiter.sv
// Combinational channel picker: first eligible index at/after the start pointer, wrapping.
module sram_rr_arbiter
    import bridge_pkg::*;
#(
    parameter int unsigned NCH = 2,
    parameter int unsigned RR  = 0
) (
    input  logic [NCH-1:0]        i_elig,
    input  logic [idx_w(NCH)-1:0] i_ptr,
    output logic [idx_w(NCH)-1:0] o_idx_c,
    output logic                  o_vld_c
);
    localparam int unsigned IW = idx_w(NCH);

    logic [IW-1:0] w_start;
    logic [IW-1:0] w_hi_idx;
    logic          w_hi_vld;

    // Fixed priority is the round-robin search pinned to a zero start.
    assign w_start = (RR != 0) ? i_ptr : '0;

    always_comb begin
        o_idx_c  = '0;
        o_vld_c  = 1'b0;
        w_hi_idx = '0;
        w_hi_vld = 1'b0;
        for (int i = int'(NCH) - 1; i >= 0; i--) begin
            if (i_elig[i]) begin
                o_idx_c = IW'(i);
                o_vld_c = 1'b1;
            end
            if (i_elig[i] && (IW'(i) >= w_start)) begin
                w_hi_idx = IW'(i);
                w_hi_vld = 1'b1;
            end
        end
        // Lowest eligible overall is the wrap-around winner.
        if (w_hi_vld) begin
            o_idx_c = w_hi_idx;
        end
    end

endmodule

// File: rtl/sram_port_bridge.sv
// Multi-channel SRAM-port to split-handshake bridge with one outstanding transaction
// and hardware-derived per-channel / global pipeline stall.
module sram_port_bridge
    import bridge_pkg::*;
#(
    parameter int unsigned NCH = 2,
    parameter int unsigned AW  = 32,
    parameter int unsigned DW  = 32,
    parameter int unsigned RR  = 0
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [NCH-1:0]          ch_en,
    input  logic [NCH*(DW/8)-1:0]   ch_wen,
    input  logic [NCH*AW-1:0]       ch_addr,
    input  logic [NCH*DW-1:0]       ch_wdata,
    output logic [NCH*DW-1:0]       ch_rdata,
    output logic [NCH-1:0]          ch_stall,
    output logic                    stall,
    input  logic                    flush,
    sram_port_bridge_if.master      mem
);
    localparam int unsigned BW = calc_bw(DW);
    localparam int unsigned IW = idx_w(NCH);

    state_e        r_state, w_state_nxt;
    logic [NCH-1:0] r_done, w_done_nxt;
    logic [IW-1:0] r_grant, w_grant_nxt;
    logic [IW-1:0] r_rr_ptr, w_rr_ptr_nxt;
    logic          r_discard, w_discard_nxt;
    logic          r_req, w_req_nxt;
    logic          r_wr, w_wr_nxt;
    logic [BW-1:0] r_wstrb, w_wstrb_nxt;
    logic [AW-1:0] r_addr, w_addr_nxt;
    logic [DW-1:0] r_wdata, w_wdata_nxt;
    logic [DW-1:0] r_rbuf [NCH];

    logic [BW-1:0] w_ch_wen   [NCH];
    logic [AW-1:0] w_ch_addr  [NCH];
    logic [DW-1:0] w_ch_wdata [NCH];
    logic [NCH-1:0] w_elig;
    logic [IW-1:0] w_arb_idx;
    logic          w_arb_vld;
    logic          w_keep;
    logic          w_rbuf_we;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        assign w_ch_wen[g]          = ch_wen[g*BW +: BW];
        assign w_ch_addr[g]         = ch_addr[g*AW +: AW];
        assign w_ch_wdata[g]        = ch_wdata[g*DW +: DW];
        assign ch_rdata[g*DW +: DW] = r_rbuf[g];
    end

    assign ch_stall = ch_en & ~r_done;
    assign stall    = |ch_stall;
    assign w_elig   = ch_en & ~r_done;

    // A flush in the response cycle drops the result just like a pending discard.
    assign w_keep    = ~r_discard & ~flush;
    assign w_rbuf_we = (r_state == DATA) & mem.mem_data_ok & w_keep & ~r_wr;

    sram_rr_arbiter #(
        .NCH (NCH),
        .RR  (RR)
    ) u_arb (
        .i_elig  (w_elig),
        .i_ptr   (r_rr_ptr),
        .o_idx_c (w_arb_idx),
        .o_vld_c (w_arb_vld)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= IDLE;
            r_done    <= '0;
            r_grant   <= '0;
            r_rr_ptr  <= '0;
            r_discard <= 1'b0;
            r_req     <= 1'b0;
            r_wr      <= 1'b0;
            r_wstrb   <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_done    <= w_done_nxt;
            r_grant   <= w_grant_nxt;
            r_rr_ptr  <= w_rr_ptr_nxt;
            r_discard <= w_discard_nxt;
            r_req     <= w_req_nxt;
            r_wr      <= w_wr_nxt;
            r_wstrb   <= w_wstrb_nxt;
            r_addr    <= w_addr_nxt;
            r_wdata   <= w_wdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_done_nxt    = r_done;
        w_grant_nxt   = r_grant;
        w_rr_ptr_nxt  = r_rr_ptr;
        w_discard_nxt = r_discard;
        w_req_nxt     = r_req;
        w_wr_nxt      = r_wr;
        w_wstrb_nxt   = r_wstrb;
        w_addr_nxt    = r_addr;
        w_wdata_nxt   = r_wdata;

        // Core advanced (or flushed): previously completed results are consumed.
        if (!stall || flush) begin
            w_done_nxt = '0;
        end

        unique case (r_state)
            IDLE: begin
                if (!flush && w_arb_vld) begin
                    w_state_nxt  = ADDR;
                    w_grant_nxt  = w_arb_idx;
                    w_rr_ptr_nxt = (w_arb_idx == IW'(NCH - 1)) ? '0 : IW'(w_arb_idx + IW'(1));
                    w_req_nxt    = 1'b1;
                    w_wstrb_nxt  = w_ch_wen[w_arb_idx];
                    w_wr_nxt     = |w_ch_wen[w_arb_idx];
                    w_addr_nxt   = w_ch_addr[w_arb_idx];
                    w_wdata_nxt  = w_ch_wdata[w_arb_idx];
                end
            end
            ADDR: begin
                if (flush) begin
                    w_discard_nxt = 1'b1;
                end
                if (mem.mem_addr_ok) begin
                    w_state_nxt = DATA;
                    w_req_nxt   = 1'b0;
                end
            end
            DATA: begin
                if (flush) begin
                    w_discard_nxt = 1'b1;
                end
                if (mem.mem_data_ok) begin
                    w_state_nxt   = IDLE;
                    w_discard_nxt = 1'b0;
                    if (w_keep) begin
                        w_done_nxt[r_grant] = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(NCH); i++) begin
                r_rbuf[i] <= '0;
            end
        end else if (w_rbuf_we) begin
            r_rbuf[r_grant] <= mem.mem_rdata;
        end
    end

    assign mem.mem_req   = r_req;
    assign mem.mem_wr    = r_wr;
    assign mem.mem_wstrb = r_wstrb;
    assign mem.mem_addr  = r_addr;
    assign mem.mem_wdata = r_wdata;

endmodule

// File: tb/tb_sram_port_bridge.sv
// Directed bench: a fixed-priority 2-channel bridge and a round-robin 3-channel bridge,
// each behind a small delay-programmable memory responder.
module tb_sram_port_bridge;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    // dut0: NCH=2, RR=0
    logic [1:0]  en0 = '0;
    logic [7:0]  wen0 = '0;
    logic [63:0] addr0 = '0, wdata0 = '0, rdata0_o;
    logic [1:0]  chst0;
    logic        st0;
    logic        flush0 = 1'b0;
    // dut1: NCH=3, RR=1
    logic [2:0]  en1 = '0;
    logic [11:0] wen1 = '0;
    logic [95:0] addr1 = '0, wdata1 = '0, rdata1_o;
    logic [2:0]  chst1;
    logic        st1;
    logic        flush1 = 1'b0;

    sram_port_bridge_if #(.AW(32), .DW(32)) m0 ();
    sram_port_bridge_if #(.AW(32), .DW(32)) m1 ();

    sram_port_bridge #(.NCH(2), .AW(32), .DW(32), .RR(0)) u_dut0 (
        .clk(clk), .resetn(resetn), .ch_en(en0), .ch_wen(wen0), .ch_addr(addr0),
        .ch_wdata(wdata0), .ch_rdata(rdata0_o), .ch_stall(chst0), .stall(st0),
        .flush(flush0), .mem(m0)
    );

    sram_port_bridge #(.NCH(3), .AW(32), .DW(32), .RR(1)) u_dut1 (
        .clk(clk), .resetn(resetn), .ch_en(en1), .ch_wen(wen1), .ch_addr(addr1),
        .ch_wdata(wdata1), .ch_rdata(rdata1_o), .ch_stall(chst1), .stall(st1),
        .flush(flush1), .mem(m1)
    );

    // Responder state and transaction log, index 0 -> dut0, 1 -> dut1.
    logic        aok [2];
    logic        dok [2];
    logic [31:0] rdat [2];
    logic        in_data [2];
    int          acnt [2], dcnt [2];
    int          addr_wait [2], data_wait [2];
    logic [31:0] rd_val [2];
    bit          manual = 1'b0;
    logic [31:0] lg_addr [2][16];
    logic        lg_wr   [2][16];
    logic [3:0]  lg_strb [2][16];
    logic [31:0] lg_wd   [2][16];
    int          lg_n [2];

    logic        req_w [2];
    logic        mwr_w [2];
    logic [3:0]  mstrb_w [2];
    logic [31:0] maddr_w [2], mwd_w [2];

    assign req_w[0] = m0.mem_req;   assign req_w[1] = m1.mem_req;
    assign mwr_w[0] = m0.mem_wr;    assign mwr_w[1] = m1.mem_wr;
    assign mstrb_w[0] = m0.mem_wstrb; assign mstrb_w[1] = m1.mem_wstrb;
    assign maddr_w[0] = m0.mem_addr;  assign maddr_w[1] = m1.mem_addr;
    assign mwd_w[0] = m0.mem_wdata;   assign mwd_w[1] = m1.mem_wdata;

    assign m0.mem_addr_ok = aok[0];
    assign m0.mem_data_ok = dok[0];
    assign m0.mem_rdata   = rdat[0];
    assign m1.mem_addr_ok = aok[1];
    assign m1.mem_data_ok = dok[1];
    assign m1.mem_rdata   = rdat[1];

    initial begin
        for (int d = 0; d < 2; d++) begin
            aok[d] = 1'b0; dok[d] = 1'b0; rdat[d] = '0; in_data[d] = 1'b0;
            acnt[d] = 0; dcnt[d] = 0; addr_wait[d] = 0; data_wait[d] = 0;
            rd_val[d] = '0; lg_n[d] = 0;
        end
    end

    // Memory model: addr_ok after addr_wait cycles of mem_req, data_ok data_wait cycles later.
    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            if (!resetn) begin
                aok[d] = 1'b0; dok[d] = 1'b0; in_data[d] = 1'b0; acnt[d] = 0; dcnt[d] = 0;
            end else if (!manual) begin
                if (aok[d]) begin
                    aok[d] = 1'b0; in_data[d] = 1'b1; dcnt[d] = 0;
                end else if (dok[d]) begin
                    dok[d] = 1'b0; in_data[d] = 1'b0;
                end
                if (in_data[d]) begin
                    if (dcnt[d] == data_wait[d]) begin
                        dok[d] = 1'b1; rdat[d] = rd_val[d];
                    end else begin
                        dcnt[d]++;
                    end
                end else if (req_w[d]) begin
                    if (acnt[d] == addr_wait[d]) begin
                        aok[d] = 1'b1; acnt[d] = 0;
                        if (lg_n[d] < 16) begin
                            lg_addr[d][lg_n[d]] = maddr_w[d];
                            lg_wr[d][lg_n[d]]   = mwr_w[d];
                            lg_strb[d][lg_n[d]] = mstrb_w[d];
                            lg_wd[d][lg_n[d]]   = mwd_w[d];
                        end
                        lg_n[d]++;
                    end else begin
                        acnt[d]++;
                    end
                end
            end
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts stalled cycles (sampled at negedge) until the selected bridge stops stalling.
    task automatic wait_free(input int d, input bit lat, input logic [31:0] lat_addr, output int n);
        logic stv;
        bit   fin;
        n   = 0;
        fin = 1'b0;
        stv = 1'b1;
        for (int c = 0; c < 60 && !fin; c++) begin
            @(negedge clk);
            stv = (d == 0) ? st0 : st1;
            if (!stv) begin
                fin = 1'b1;
            end else begin
                n++;
                if (lat && m0.mem_req) begin
                    check_eq("t4_addr_hold", m0.mem_addr, lat_addr);
                    check_eq("t4_wr_hold", 32'(m0.mem_wr), 32'd0);
                end
            end
        end
        if (!fin) begin
            check_eq("stall_timeout", 32'(stv), 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        logic [31:0] exp_a;

        #2;
        check_eq("rst_mem_req", 32'(m0.mem_req), 32'd0);
        check_eq("rst_mem_addr", m0.mem_addr, 32'd0);
        check_eq("rst_rdata", rdata0_o[31:0], 32'd0);
        tick();
        tick();
        resetn = 1'b1;

        // Single zero-wait read: three stall cycles, data visible in the fourth.
        tick();
        rd_val[0] = 32'h24080001;
        addr0[31:0] = 32'h1FC00000;
        en0 = 2'b01;
        wait_free(0, 1'b0, 32'd0, n);
        check_eq("t1_stall_cycles", 32'(n), 32'd3);
        check_eq("t1_rdata", rdata0_o[31:0], 32'h24080001);
        check_eq("t1_addr", lg_addr[0][0], 32'h1FC00000);
        check_eq("t1_wr", 32'(lg_wr[0][0]), 32'd0);
        en0 = 2'b00;

        // Simultaneous ch0 read and ch1 write, fixed priority.
        tick();
        base = lg_n[0];
        rd_val[0] = 32'h11112222;
        addr0 = {32'h00000200, 32'h00000100};
        wen0 = 8'hF0;
        wdata0 = {32'hDEADBEEF, 32'h00000000};
        en0 = 2'b11;
        wait_free(0, 1'b0, 32'd0, n);
        check_eq("t2_stall_cycles", 32'(n), 32'd6);
        check_eq("t2_first_addr", lg_addr[0][base], 32'h00000100);
        check_eq("t2_first_wr", 32'(lg_wr[0][base]), 32'd0);
        check_eq("t2_second_addr", lg_addr[0][base+1], 32'h00000200);
        check_eq("t2_second_wr", 32'(lg_wr[0][base+1]), 32'd1);
        check_eq("t2_second_strb", 32'(lg_strb[0][base+1]), 32'hF);
        check_eq("t2_second_wdata", lg_wd[0][base+1], 32'hDEADBEEF);
        check_eq("t2_rdata0", rdata0_o[31:0], 32'h11112222);
        check_eq("t2_rdata1_untouched", rdata0_o[63:32], 32'd0);
        @(negedge clk);
        check_eq("t2_done_cleared", 32'(chst0), 32'h3);
        en0 = 2'b00;
        wen0 = '0;
        wdata0 = '0;

        // Flush during the response phase of a ch1 read.
        tick();
        data_wait[0] = 2;
        rd_val[0] = 32'hCAFEF00D;
        addr0[63:32] = 32'h00000300;
        en0 = 2'b10;
        tick();
        tick();
        flush0 = 1'b1;
        @(negedge clk);
        check_eq("t3_req_low_in_data", 32'(m0.mem_req), 32'd0);
        tick();
        flush0 = 1'b0;
        tick();
        tick();
        rd_val[0] = 32'h0BADC0DE;
        @(negedge clk);
        check_eq("t3_rbuf_kept", rdata0_o[63:32], 32'd0);
        check_eq("t3_still_stalled", 32'(chst0[1]), 32'd1);
        check_eq("t3_no_req_idle", 32'(m0.mem_req), 32'd0);
        tick();
        @(negedge clk);
        check_eq("t3_regrant_req", 32'(m0.mem_req), 32'd1);
        check_eq("t3_regrant_addr", m0.mem_addr, 32'h00000300);
        wait_free(0, 1'b0, 32'd0, n);
        check_eq("t3_tail_cycles", 32'(n), 32'd3);
        check_eq("t3_rdata_new", rdata0_o[63:32], 32'h0BADC0DE);
        en0 = 2'b00;
        data_wait[0] = 0;

        // addr_ok held off four cycles; request fields stay latched.
        tick();
        addr_wait[0] = 4;
        rd_val[0] = 32'h44440000;
        addr0[31:0] = 32'h00004444;
        en0 = 2'b01;
        @(negedge clk);
        check_eq("t4_stall_c0", 32'(st0), 32'd1);
        tick();
        addr0[31:0] = 32'hFFFF0000;
        wait_free(0, 1'b1, 32'h00004444, n);
        check_eq("t4_stall_cycles", 32'(n + 1), 32'd7);
        check_eq("t4_rdata", rdata0_o[31:0], 32'h44440000);
        en0 = 2'b00;
        addr_wait[0] = 0;

        // Reset in the response phase, then a stray data_ok.
        tick();
        data_wait[0] = 3;
        addr0[31:0] = 32'h00000500;
        en0 = 2'b01;
        tick();
        tick();
        @(negedge clk);
        check_eq("t5_pre_addr", m0.mem_addr, 32'h00000500);
        manual = 1'b1;
        resetn = 1'b0;
        en0 = 2'b00;
        #1;
        check_eq("t5_rst_req", 32'(m0.mem_req), 32'd0);
        check_eq("t5_rst_addr", m0.mem_addr, 32'd0);
        check_eq("t5_rst_strb", 32'(m0.mem_wstrb), 32'd0);
        check_eq("t5_rst_rdata", rdata0_o[31:0], 32'd0);
        tick();
        tick();
        resetn = 1'b1;
        tick();
        dok[0] = 1'b1;
        rdat[0] = 32'h99999999;
        @(negedge clk);
        check_eq("t5_late_ok_req", 32'(m0.mem_req), 32'd0);
        tick();
        dok[0] = 1'b0;
        @(negedge clk);
        check_eq("t5_late_ok_rdata", rdata0_o[31:0], 32'd0);
        manual = 1'b0;
        data_wait[0] = 0;
        tick();
        rd_val[0] = 32'h12345678;
        addr0[31:0] = 32'h00000600;
        en0 = 2'b01;
        wait_free(0, 1'b0, 32'd0, n);
        check_eq("t5_post_stall", 32'(n), 32'd3);
        check_eq("t5_post_rdata", rdata0_o[31:0], 32'h12345678);
        en0 = 2'b00;

        // Round robin, three channels held for two full rounds.
        tick();
        base = lg_n[1];
        rd_val[1] = 32'h5A5A0000;
        addr1 = {32'h00003000, 32'h00002000, 32'h00001000};
        en1 = 3'b111;
        wait_free(1, 1'b0, 32'd0, n);
        check_eq("t6_round1_cycles", 32'(n), 32'd9);
        wait_free(1, 1'b0, 32'd0, n);
        check_eq("t6_round2_cycles", 32'(n), 32'd9);
        en1 = 3'b000;
        for (int k = 0; k < 6; k++) begin
            exp_a = 32'h1000 * 32'((k % 3) + 1);
            check_eq("t6_grant_order", lg_addr[1][base+k], exp_a);
        end
        check_eq("t6_rdata2", rdata1_o[95:64], 32'h5A5A0000);

        // Pointer sits past ch1, so ch2 must beat ch0.
        tick();
        en1 = 3'b010;
        wait_free(1, 1'b0, 32'd0, n);
        check_eq("t7_single_cycles", 32'(n), 32'd3);
        en1 = 3'b000;
        tick();
        base = lg_n[1];
        en1 = 3'b101;
        wait_free(1, 1'b0, 32'd0, n);
        check_eq("t7_pair_cycles", 32'(n), 32'd6);
        check_eq("t7_rr_first", lg_addr[1][base], 32'h00003000);
        check_eq("t7_rr_second", lg_addr[1][base+1], 32'h00001000);
        en1 = 3'b000;

        tick();
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/sram_port_bridge.md
# sram_port_bridge

Parametrised multi-channel bridge between the core's SRAM-style ports (instruction, data, optionally more) and one shared split-handshake memory port. It arbitrates channels and keeps one transaction outstanding. It generates the per-channel and global stall consumed by the pipeline, and returns a registered read buffer per channel. It replaces the fixed `instrStall`/`dataStall` pair at the core top with one block whose stall behaviour is derived in hardware.

## Interface
- NCH, 2: number of core-side channels; index 0 has highest fixed priority.
- AW, 32: address width.
- DW, 32: data width, a multiple of 8; BW = DW/8.
- RR, 0: 0 selects fixed priority, 1 selects round-robin.
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- ch_en  in  NCH  channel request valid; held by the core while stalled.
- ch_wen  in  NCH*BW  byte write enables; all zero means read.
- ch_addr  in  NCH*AW  channel address.
- ch_wdata  in  NCH*DW  channel write data.
- ch_rdata  out  NCH*DW  per-channel read buffer, registered.
- ch_stall  out  NCH  per-channel stall.
- stall  out  1  OR of ch_stall; the pipeline freezes while it is high.
- flush  in  1  exception flush; discards results of pending requests.
- mem_req  out  1  request valid.
- mem_wr  out  1  1 = write.
- mem_wstrb  out  BW  byte strobes.
- mem_addr  out  AW  request address.
- mem_wdata  out  DW  write data.
- mem_addr_ok  in  1  request accepted.
- mem_rdata  in  DW  read data.
- mem_data_ok  in  1  response; also completes writes.

## Operation
- State machine has three states: IDLE, ADDR, DATA.
- Per-channel registers: done[i] and rbuf[i]. Global registers: grant index, discard flag, and the round-robin pointer rr_ptr.
- Output equations: ch_stall[i] = ch_en[i] & ~done[i]; ch_rdata[i] = rbuf[i].
- Eligibility: channel i is eligible when ch_en[i] & ~done[i].
- IDLE: if flush = 0 and any channel is eligible, grant one. Latch its wen, addr and wdata into the request registers, then go to ADDR.
  - RR = 0: the lowest eligible index wins.
  - RR = 1: the first eligible index at or after rr_ptr wins. rr_ptr becomes grant+1, modulo NCH.
- ADDR: mem_req = 1 with the latched fields; mem_wr = |wen. On mem_addr_ok, go to DATA. The request is never retracted, even by flush.
- DATA: mem_req = 0. On mem_data_ok:
  - If discard = 0, set done[grant]; on a read, rbuf[grant] takes mem_rdata.
  - Clear discard and return to IDLE.
  - mem_data_ok is ignored outside DATA.
- Pipeline advance: when stall = 0 at a clock edge, all done[] are cleared at that edge, because the core has advanced.
- Flush:
  - All done[] clear at the edge.
  - If the state is ADDR or DATA, discard sets; the transaction drains and its result is dropped.
  - No grant is made in a cycle where flush = 1.
  - The write side effect of an already-issued request still occurs.
- When discard = 1 and data_ok arrives, neither done nor rbuf changes.
- rbuf keeps its value until the next non-discarded read on that channel.
- ch_en falling while a transaction is in flight does not abort it; the result is recorded and done clears on the next stall-free edge.

## Timing
- Reset values: state IDLE, mem_req 0, mem_wr 0, mem_wstrb 0, mem_addr 0, mem_wdata 0, all done 0, all rbuf 0, rr_ptr 0, discard 0.
- ch_stall and stall are asserted combinationally in the same cycle ch_en rises.
- Minimum read latency:
  - cycle 0: en rises.
  - cycle 1: mem_req = 1, addr_ok = 1.
  - cycle 2: data_ok = 1.
  - cycle 3: ch_stall = 0, rdata valid.
  - The result is 3 stall cycles. Each addr_ok or data_ok wait cycle adds one.
- Two channels requesting together are serviced back to back: the second grant is made in the IDLE cycle after the first data_ok. The global stall stays high until both are done.
- Only one transaction is outstanding. data_ok is never expected in the same cycle as addr_ok.

## Structure
- Shared package `bridge_pkg` holds the state enum (IDLE/ADDR/DATA) and the function computing BW from DW.
- One sub-module, `sram_rr_arbiter`. Parameters are NCH and RR. Inputs are the eligible vector and rr_ptr; outputs are the grant index and a valid bit. It is purely combinational and also used for fixed priority.

## Test plan
- Single read, ch0 addr 0x1FC00000, memory returns 0x24080001 with zero wait → stall high for cycles 0–2, ch_rdata[0] = 0x24080001 in cycle 3.
- ch0 read and ch1 write (wen = 4'hF, wdata 0xDEADBEEF) in the same cycle, RR = 0 → ch0 issued first, ch1 second. The write is seen with mem_wstrb = 4'hF. stall drops only after both complete, and done clears at that edge.
- RR = 1, NCH = 3, all channels request continuously for 6 transactions → grant order 0,1,2,0,1,2.
- flush asserted while in DATA for a ch1 read → data_ok is consumed, rbuf[1] is unchanged, done[1] = 0, and the next request is granted only after return to IDLE.
- addr_ok delayed 4 cycles → mem_req and the latched fields stay stable the whole time; total stall is 7 cycles.
- resetn deasserted mid-DATA → all outputs return to their reset values immediately. A late data_ok after reset release is ignored.
